// File: rtl/sb_trans_arbiter.sv
// sb_trans_arbiter: grants one of three sideband requesters and tracks the transaction to ack, timeout or abort.
// Round-robin by default; define SB_ARB_STRICT_PRIO_EN for fixed priority 0 > 1 > 2.
module sb_trans_arbiter #(
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic       sb_clk,
  input  logic       rst,
  input  logic [2:0] req_valid,
  input  logic [2:0] req_code_0,
  input  logic [2:0] req_code_1,
  input  logic [2:0] req_code_2,
  input  logic       disconnect_sbtx,
  input  logic       trans_sent,
  output logic [2:0] trans_sel,
  output logic [2:0] req_ack,
  output logic [2:0] req_err,
  output logic [1:0] grant_id,
  output logic       busy
);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_SENT, GAP} state_t;
  localparam state_t DONE_ST = GAP_CYCLES == 0 ? IDLE : GAP;
  state_t state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [2:0] sel_q, sel_d, ack_q, ack_d, err_q, err_d, win_oh, pick_code;
  logic [1:0] win_q, win_d, start, pick;
  logic [1:0] cand [3];
  logic busy_q, busy_d, grant;
  assign grant = state_q == IDLE && !disconnect_sbtx && |req_valid;
`ifdef SB_ARB_STRICT_PRIO_EN
  assign start = 2'd0;
`else
  logic [1:0] last_q, last_d;
  assign start  = last_q == 2'd2 ? 2'd0 : last_q + 2'd1;
  assign last_d = grant ? pick : last_q;
  always_ff @(posedge sb_clk or posedge rst)
    if (rst) last_q <= 2'd2;
    else     last_q <= last_d;
`endif
  // Candidates in search order, starting from the highest-priority slot.
  assign cand[0]   = start;
  assign cand[1]   = start == 2'd2 ? 2'd0 : start + 2'd1;
  assign cand[2]   = start == 2'd0 ? 2'd2 : start - 2'd1;
  assign pick      = req_valid[cand[0]] ? cand[0] : req_valid[cand[1]] ? cand[1] : cand[2];
  assign pick_code = pick == 2'd0 ? req_code_0 : pick == 2'd1 ? req_code_1 : req_code_2;
  assign win_oh    = 3'(1) << win_q;
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    gap_d   = '0;
    sel_d   = '0;
    ack_d   = '0;
    err_d   = '0;
    case (state_q)
      IDLE: if (grant) begin
        win_d = pick;
        if (pick_code == 3'b000) ack_d = 3'(1) << pick;
        else begin
          sel_d   = pick_code;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        err_d   = disconnect_sbtx ? win_oh : 3'b000;
        state_d = disconnect_sbtx ? DONE_ST : WAIT_SENT;
      end
      WAIT_SENT: begin
        cnt_d = cnt_q + 10'd1;
        if (trans_sent) begin
          ack_d   = win_oh;
          state_d = DONE_ST;
        end else if (disconnect_sbtx || cnt_q == TO_LAST) begin
          err_d   = win_oh;
          state_d = DONE_ST;
        end
      end
      default: begin
        gap_d   = gap_q + GW'(1);
        state_d = gap_q == GAP_LAST ? IDLE : GAP;
      end
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge sb_clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      sel_q   <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  assign trans_sel = sel_q;
  assign req_ack   = ack_q;
  assign req_err   = err_q;
  assign grant_id  = win_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_sb_trans_arbiter.sv
// tb_sb_trans_arbiter: directed scenarios for sb_trans_arbiter checked against a timestamp-based model every cycle.
module tb_sb_trans_arbiter;
  localparam int GAP = 4, TO = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] valid = '0, c0 = '0, c1 = '0, c2 = '0;
  logic disc = 1'b0, sent = 1'b0;
  logic [2:0] trans_sel, req_ack, req_err;
  logic [1:0] grant_id;
  logic busy;
  int checks = 0, errors = 0;
  int t = 0, free_at = 0, launch = 0, last = 2;
  bit active = 0;
  logic [2:0] e_sel = '0, e_ack = '0, e_err = '0;
  logic [1:0] e_gid = '0;
  logic e_busy = 1'b0;

  always #5 clk = ~clk;

  sb_trans_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .sb_clk(clk), .rst(rst), .req_valid(valid),
    .req_code_0(c0), .req_code_1(c1), .req_code_2(c2),
    .disconnect_sbtx(disc), .trans_sent(sent),
    .trans_sel(trans_sel), .req_ack(req_ack), .req_err(req_err),
    .grant_id(grant_id), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [2:0] code_of(input int i);
    return i == 0 ? c0 : i == 1 ? c1 : c2;
  endfunction

  // Model: an outstanding transaction launched at cycle 'launch'; arbiter may grant again from cycle 'free_at'.
  task automatic m_reset();
    active = 0; free_at = 0; last = 2;
    e_sel = '0; e_ack = '0; e_err = '0; e_gid = '0; e_busy = 1'b0;
  endtask

  task automatic m_done(input bit ok);
    if (ok) e_ack = 3'(1) << e_gid;
    else    e_err = 3'(1) << e_gid;
    active  = 0;
    free_at = t + 1 + GAP;
  endtask

  task automatic m_step();
    int w;
    e_sel = '0; e_ack = '0; e_err = '0;
    if (!active && t >= free_at) begin
      if (!disc && valid != 0) begin
`ifdef SB_ARB_STRICT_PRIO_EN
        w = valid[0] ? 0 : valid[1] ? 1 : 2;
`else
        w = -1;
        for (int k = 1; k <= 3; k++) if (w < 0 && valid[(last + k) % 3]) w = (last + k) % 3;
        last = w;
`endif
        e_gid = 2'(w);
        if (code_of(w) == 0) begin
          e_ack   = 3'(1 << w);
          free_at = t + 1;
        end else begin
          e_sel  = code_of(w);
          active = 1;
          launch = t + 1;
        end
      end
    end else if (active) begin
      if (t == launch) begin
        if (disc) m_done(0);
      end else if (sent) m_done(1);
      else if (disc || t - launch - 1 == TO - 1) m_done(0);
    end
    e_busy = active || (t + 1 < free_at);
  endtask

  always @(negedge clk) begin
    if (rst) m_reset();
    chk("trans_sel", trans_sel, e_sel);
    chk("req_ack", req_ack, e_ack);
    chk("req_err", req_err, e_err);
    chk("grant_id", grant_id, e_gid);
    chk("busy", busy, e_busy);
    if (!rst) m_step();
    t++;
  end

  task automatic step();
    @(posedge clk);
    #1;
    valid = valid & ~(req_ack | req_err);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_sel();
    int n = 0;
    while (trans_sel == 0 && n < 60) begin step(); n++; end
    chk("wait trans_sel", trans_sel != 0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin step(); n++; end
    chk("wait idle", busy, 0);
  endtask

  initial begin
    int n, g;
    logic [1:0] order [4];
    logic [1:0] want [4];
`ifdef SB_ARB_STRICT_PRIO_EN
    want = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
    want = '{2'd0, 2'd1, 2'd2, 2'd0};
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    // Single request: launch next cycle, ack after trans_sent, four gap cycles.
    c0 = 3'b011; valid = 3'b001;
    step();
    chk("s1 sel latency", trans_sel, 3'b011);
    chk("s1 gid", grant_id, 0);
    repeat (5) step();
    sent = 1'b1; step(); sent = 1'b0;
    chk("s1 ack", req_ack, 3'b001);
    n = 0;
    while (busy && n < 10) begin n++; step(); end
    chk("s1 gap cycles", n, GAP);
    // Contention with all requesters held.
    do_reset();
    c0 = 3'd1; c1 = 3'd2; c2 = 3'd3; valid = 3'b111;
    for (int i = 0; i < 4; i++) begin
      wait_sel();
      order[i] = grant_id;
      step();
      sent = 1'b1; step(); sent = 1'b0;
      chk("s2 ack", req_ack, 3'(1) << order[i]);
      valid = 3'b111;
    end
    valid = '0;
    for (int i = 0; i < 4; i++) chk("s2 grant order", order[i], want[i]);
    // Timeout with no trans_sent.
    c1 = 3'd5; valid = 3'b010;
    wait_sel();
    n = 0;
    while (req_err == 0 && req_ack == 0 && n < 20) begin step(); n++; end
    chk("s3 timeout cycles", n, TO + 1);
    chk("s3 err", req_err, 3'b010);
    chk("s3 no ack", req_ack, 0);
    chk("s3 gap busy", busy, 1);
    // trans_sent on the timeout cycle: ack only.
    c2 = 3'd7; valid = 3'b100;
    wait_sel();
    repeat (TO) step();
    sent = 1'b1; step(); sent = 1'b0;
    chk("s4 ack", req_ack, 3'b100);
    chk("s4 no err", req_err, 0);
    // Code 000: ack with no launch.
    wait_idle();
    c0 = 3'b000; valid = 3'b001;
    step();
    chk("s5 ack", req_ack, 3'b001);
    chk("s5 no sel", trans_sel, 0);
    chk("s5 idle", busy, 0);
    // Disconnect two cycles into WAIT_SENT, then no grants while disconnected.
    c0 = 3'd2; c1 = 3'd4; valid = 3'b011;
    wait_sel();
    g = grant_id;
    repeat (3) step();
    disc = 1'b1;
    step();
    chk("s6 err", req_err, 3'(1) << g);
    chk("s6 no ack", req_ack, 0);
    valid = 3'b111;
    n = 0;
    repeat (20) begin step(); if (trans_sel != 0) n++; end
    chk("s6 no sel while disconnected", n, 0);
    valid = '0; disc = 1'b0;
    // Reset during WAIT_SENT discards the transaction; requester 0 wins next.
    wait_idle();
    c0 = 3'd1; c2 = 3'd6; valid = 3'b100;
    wait_sel();
    chk("s7 gid before rst", grant_id, 2);
    repeat (2) step();
    rst = 1'b1;
    #1;
    chk("s7 rst sel", trans_sel, 0);
    chk("s7 rst busy", busy, 0);
    chk("s7 rst gid", grant_id, 0);
    chk("s7 rst ack err", {req_ack, req_err}, 0);
    step(); step();
    rst = 1'b0; valid = 3'b111; sent = 1'b1;
    step();
    sent = 1'b0;
    chk("s7 gid after rst", grant_id, 0);
    chk("s7 sel after rst", trans_sel, 3'd1);
    step();
    sent = 1'b1; step(); sent = 1'b0;
    chk("s7 ack", req_ack, 3'b001);
    valid = '0;
    wait_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
